// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ byte-stream requesters. The grant is
// handed out round-robin and held for a whole message (up to the byte marked
// req_last), so lines from different sources never interleave. A locked owner
// that offers no byte for LOCK_TIMEOUT SEND cycles loses the grant.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      per-requester byte valid
//   req_data       byte per requester, requester i on [8*i +: 8]
//   req_last       per-requester end-of-message marker
//   req_ready      combinational ready, only ever set for the owner in SEND
//   grant          registered one-hot owner, zero when idle
//   tx_data        byte to the UART core, held until the next transfer
//   tx_send        single-cycle send pulse to the UART core
//   tx_busy        UART core busy (rises the cycle after tx_send)
//   timeout_evt    single-cycle pulse when a stalled owner is dropped
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     grant,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    input  logic                 tx_busy,
    output logic                 timeout_evt
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGuard, StWaitTx} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_send_q, tx_send_d;
    logic               timeout_q, timeout_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   next_ptr;

    // First valid requester at or after rr_ptr, with wrap. Iterating from the far
    // end lets the nearest candidate overwrite the others.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % int'(N_REQ));
            if (req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Priority moves to the requester after the one being released.
    assign next_ptr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        last_d     = last_q;
        idle_cnt_d = idle_cnt_q;
        tx_data_d  = tx_data_q;
        tx_send_d  = 1'b0;
        timeout_d  = 1'b0;
        req_ready  = '0;

        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    idle_cnt_d        = '0;
                    state_d           = StSend;
                end
            end
            StSend: begin
                req_ready[owner_q] = !tx_busy;
                if (req_valid[owner_q] && !tx_busy) begin
                    tx_data_d  = req_data[{owner_q, 3'b000} +: 8];
                    tx_send_d  = 1'b1;
                    last_d     = req_last[owner_q];
                    idle_cnt_d = '0;
                    state_d    = StGuard;
                end else if (!req_valid[owner_q]) begin
                    if (idle_cnt_q == CNT_MAX) begin
                        // Stalled owner: abandon the partial message.
                        timeout_d  = 1'b1;
                        grant_d    = '0;
                        rr_ptr_d   = next_ptr;
                        idle_cnt_d = '0;
                        state_d    = StIdle;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
            end
            // The core only raises tx_busy the cycle after tx_send; skip that cycle.
            StGuard: begin
                state_d = StWaitTx;
            end
            StWaitTx: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = StIdle;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            last_q     <= 1'b0;
            idle_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_send_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            last_q     <= last_d;
            idle_cnt_q <= idle_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_send     = tx_send_q;
    assign timeout_evt = timeout_q;

endmodule
